jtag_tap_multi_dr: RTL

Parametrised IEEE 1149.1-style TAP controller, the next generation of the team's single-register TAP. It adds a real shift/capture/update architecture, a configurable-width instruction register, mandatory BYPASS and IDCODE registers, and NUM_USER_DR user data registers selected by instruction. It sits between the board JTAG pins and on-chip debug/config logic. All logic runs on TCK, presented as clk.

---
 rtl/jtag_pkg.sv | 53 +++++
 rtl/jtag_tap_multi_dr_if.sv | 32 +++
 rtl/jtag_tap_fsm.sv | 58 +++++
 rtl/jtag_tap_multi_dr.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared TAP definitions: the 16-state controller encoding, instruction constants
// and the IEEE 1149.1 state transition function.
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR      = 4'd0,
        RTI      = 4'd1,
        SEL_DR   = 4'd2,
        CAP_DR   = 4'd3,
        SHIFT_DR = 4'd4,
        EXIT1_DR = 4'd5,
        PAUSE_DR = 4'd6,
        EXIT2_DR = 4'd7,
        UPD_DR   = 4'd8,
        SEL_IR   = 4'd9,
        CAP_IR   = 4'd10,
        SHIFT_IR = 4'd11,
        EXIT1_IR = 4'd12,
        PAUSE_IR = 4'd13,
        EXIT2_IR = 4'd14,
        UPD_IR   = 4'd15
    } tap_state_e;

    localparam int IR_IDCODE    = 1;
    localparam int IR_USER_BASE = 2;
    localparam int IDCODE_LEN   = 32;

    function automatic tap_state_e next_state(input tap_state_e state, input logic tms);
        tap_state_e nxt;
        nxt = TLR;
        case (state)
            TLR:      nxt = tms ? TLR      : RTI;
            RTI:      nxt = tms ? SEL_DR   : RTI;
            SEL_DR:   nxt = tms ? SEL_IR   : CAP_DR;
            CAP_DR:   nxt = tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: nxt = tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: nxt = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: nxt = tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: nxt = tms ? UPD_DR   : SHIFT_DR;
            UPD_DR:   nxt = tms ? SEL_DR   : RTI;
            SEL_IR:   nxt = tms ? TLR      : CAP_IR;
            CAP_IR:   nxt = tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: nxt = tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: nxt = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: nxt = tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: nxt = tms ? UPD_IR   : SHIFT_IR;
            UPD_IR:   nxt = tms ? SEL_DR   : RTI;
            default:  nxt = TLR;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jtag_tap_multi_dr_if.sv
// Pin- and debug-side signal bundle of the multi-DR TAP; the master side drives
// the JTAG pins and capture data, the slave side is the TAP itself.
interface jtag_tap_multi_dr_if
    import jtag_pkg::*;
#(
    parameter int IR_WIDTH    = 4,
    parameter int DR_WIDTH    = 32,
    parameter int NUM_USER_DR = 2
) ();

    logic                            tms;
    logic                            tdi;
    logic                            tdo;
    logic                            tdo_en;
    tap_state_e                      tap_state;
    logic [IR_WIDTH-1:0]             ir_value;
    logic                            ir_update;
    logic [NUM_USER_DR*DR_WIDTH-1:0] dr_capture_data;
    logic [DR_WIDTH-1:0]             dr_update_data;
    logic [NUM_USER_DR-1:0]          dr_update_valid;

    modport master (
        output tms, tdi, dr_capture_data,
        input  tdo, tdo_en, tap_state, ir_value, ir_update, dr_update_data, dr_update_valid
    );

    modport slave (
        input  tms, tdi, dr_capture_data,
        output tdo, tdo_en, tap_state, ir_value, ir_update, dr_update_data, dr_update_valid
    );

endinterface

// File: rtl/jtag_tap_fsm.sv
// TAP controller state machine: state register, next-state logic and decoded
// per-state strobes consumed by the register datapath.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_tms,
    output tap_state_e o_state,
    output logic       o_tlr,
    output logic       o_cap_dr,
    output logic       o_shift_dr,
    output logic       o_upd_dr,
    output logic       o_cap_ir,
    output logic       o_shift_ir,
    output logic       o_upd_ir,
    output logic       o_tdo_en
);

    tap_state_e r_state;
    tap_state_e w_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= TLR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = next_state(r_state, i_tms);
    end

    always_comb begin
        o_tlr      = 1'b0;
        o_cap_dr   = 1'b0;
        o_shift_dr = 1'b0;
        o_upd_dr   = 1'b0;
        o_cap_ir   = 1'b0;
        o_shift_ir = 1'b0;
        o_upd_ir   = 1'b0;
        case (r_state)
            TLR:      o_tlr      = 1'b1;
            CAP_DR:   o_cap_dr   = 1'b1;
            SHIFT_DR: o_shift_dr = 1'b1;
            UPD_DR:   o_upd_dr   = 1'b1;
            CAP_IR:   o_cap_ir   = 1'b1;
            SHIFT_IR: o_shift_ir = 1'b1;
            UPD_IR:   o_upd_ir   = 1'b1;
            default:  ;
        endcase
        o_tdo_en = o_shift_dr | o_shift_ir;
    end

    assign o_state = r_state;

endmodule

// File: rtl/jtag_tap_multi_dr.sv
// IEEE 1149.1-style TAP with instruction register, BYPASS, IDCODE and
// NUM_USER_DR user data registers sharing one capture/shift/update path.
module jtag_tap_multi_dr
    import jtag_pkg::*;
#(
    parameter int                    IR_WIDTH     = 4,
    parameter int                    DR_WIDTH     = 32,
    parameter int                    NUM_USER_DR  = 2,
    parameter logic [IDCODE_LEN-1:0] IDCODE_VALUE = 32'h1000_0001
) (
    input logic                clk,
    input logic                reset,
    jtag_tap_multi_dr_if.slave bus
);

    tap_state_e w_state;
    logic       w_tlr;
    logic       w_cap_dr;
    logic       w_shift_dr;
    logic       w_upd_dr;
    logic       w_cap_ir;
    logic       w_shift_ir;
    logic       w_upd_ir;
    logic       w_tdo_en;

    logic [IR_WIDTH-1:0]    r_ir_sr;
    logic                   r_bypass_sr;
    logic [IDCODE_LEN-1:0]  r_idcode_sr;
    logic [DR_WIDTH-1:0]    r_user_sr;
    logic [IR_WIDTH-1:0]    r_ir_value;
    logic                   r_ir_update;
    logic [DR_WIDTH-1:0]    r_dr_update_data;
    logic [NUM_USER_DR-1:0] r_dr_update_valid;

    logic                   w_sel_idcode;
    logic                   w_sel_user;
    logic [NUM_USER_DR-1:0] w_user_onehot;
    logic [DR_WIDTH-1:0]    w_capture_slice;
    logic                   w_tdo;

    jtag_tap_fsm u_fsm (
        .clk        (clk),
        .reset      (reset),
        .i_tms      (bus.tms),
        .o_state    (w_state),
        .o_tlr      (w_tlr),
        .o_cap_dr   (w_cap_dr),
        .o_shift_dr (w_shift_dr),
        .o_upd_dr   (w_upd_dr),
        .o_cap_ir   (w_cap_ir),
        .o_shift_ir (w_shift_ir),
        .o_upd_ir   (w_upd_ir),
        .o_tdo_en   (w_tdo_en)
    );

    // Instruction decode: codes outside IDCODE and the USER range fall through to BYPASS.
    always_comb begin
        w_user_onehot   = '0;
        w_capture_slice = '0;
        for (int k = 0; k < NUM_USER_DR; k++) begin
            if (r_ir_value == IR_WIDTH'(IR_USER_BASE + k)) begin
                w_user_onehot[k] = 1'b1;
                w_capture_slice  = bus.dr_capture_data[k*DR_WIDTH +: DR_WIDTH];
            end
        end
    end

    assign w_sel_user   = |w_user_onehot;
    assign w_sel_idcode = (r_ir_value == IR_WIDTH'(IR_IDCODE));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir_sr     <= '0;
            r_bypass_sr <= 1'b0;
            r_idcode_sr <= '0;
            r_user_sr   <= '0;
        end else begin
            if (w_cap_ir) begin
                r_ir_sr <= IR_WIDTH'(1);
            end else if (w_shift_ir) begin
                r_ir_sr <= {bus.tdi, r_ir_sr[IR_WIDTH-1:1]};
            end

            if (w_cap_dr) begin
                if (w_sel_user) begin
                    r_user_sr <= w_capture_slice;
                end else if (w_sel_idcode) begin
                    r_idcode_sr <= IDCODE_VALUE;
                end else begin
                    r_bypass_sr <= 1'b0;
                end
            end else if (w_shift_dr) begin
                if (w_sel_user) begin
                    r_user_sr <= {bus.tdi, r_user_sr[DR_WIDTH-1:1]};
                end else if (w_sel_idcode) begin
                    r_idcode_sr <= {bus.tdi, r_idcode_sr[IDCODE_LEN-1:1]};
                end else begin
                    r_bypass_sr <= bus.tdi;
                end
            end
        end
    end

    // Update pulses are registered, so they appear in the cycle after the UPD state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir_value        <= IR_WIDTH'(IR_IDCODE);
            r_ir_update       <= 1'b0;
            r_dr_update_data  <= '0;
            r_dr_update_valid <= '0;
        end else begin
            r_ir_update       <= w_upd_ir;
            r_dr_update_valid <= w_upd_dr ? w_user_onehot : '0;
            if (w_tlr) begin
                r_ir_value <= IR_WIDTH'(IR_IDCODE);
            end else if (w_upd_ir) begin
                r_ir_value <= r_ir_sr;
            end
            if (w_upd_dr && w_sel_user) begin
                r_dr_update_data <= r_user_sr;
            end
        end
    end

    always_comb begin
        w_tdo = 1'b0;
        if (w_shift_ir) begin
            w_tdo = r_ir_sr[0];
        end else if (w_shift_dr) begin
            if (w_sel_user) begin
                w_tdo = r_user_sr[0];
            end else if (w_sel_idcode) begin
                w_tdo = r_idcode_sr[0];
            end else begin
                w_tdo = r_bypass_sr;
            end
        end
    end

    assign bus.tdo             = w_tdo;
    assign bus.tdo_en          = w_tdo_en;
    assign bus.tap_state       = w_state;
    assign bus.ir_value        = r_ir_value;
    assign bus.ir_update       = r_ir_update;
    assign bus.dr_update_data  = r_dr_update_data;
    assign bus.dr_update_valid = r_dr_update_valid;

endmodule
